operand_regfile: RTL and testbench

//  Parametrised register file with one write port and two operand latch ports (A, B) feeding the ALU stage.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/operand_latch.sv | 47 ++++
 rtl/operand_regfile.sv | 102 ++++++++++
 tb/tb_operand_regfile.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the operand register file and its operand latches.
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;

    // Operand latch state: IDLE accepts loads, WAIT holds until the tagged register is written.
    typedef enum logic [0:0] {
        OP_IDLE = 1'b0,
        OP_WAIT = 1'b1
    } op_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/operand_latch.sv
// One operand port: captures a bypassed register value, or parks on a busy register's tag
// until the write that clears it arrives.
module operand_latch
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              ready,
    input  logic [AW-1:0]     readnum,
    input  logic [DATA_W-1:0] byp_value,
    input  logic              write,
    input  logic [AW-1:0]     writenum,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] operand,
    output op_state_t         state
);

    logic [AW-1:0] tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= OP_IDLE;
            tag     <= '0;
            operand <= '0;
        end else if (state == OP_IDLE) begin
            if (load) begin
                if (ready) begin
                    operand <= byp_value;
                end else begin
                    tag   <= readnum;
                    state <= OP_WAIT;
                end
            end
        end else begin
            // New loads are ignored here; only the write to the tagged register releases the port.
            if (write && (writenum == tag)) begin
                operand <= data_in;
                state   <= OP_IDLE;
            end
        end
    end

endmodule

// File: rtl/operand_regfile.sv
// Register file with a busy scoreboard and two operand latches (A, B) feeding the ALU.
// Writeback data is bypassed into the latches in the cycle it is written.
module operand_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_R0  = 0,
    localparam int AW      = clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write,
    input  logic [AW-1:0]       writenum,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                reserve,
    input  logic [AW-1:0]       reservenum,
    input  logic [AW-1:0]       readnum_a,
    input  logic [AW-1:0]       readnum_b,
    input  logic                loada,
    input  logic                loadb,
    output logic [DATA_W-1:0]   data_out,
    output logic [DATA_W-1:0]   A,
    output logic [DATA_W-1:0]   B,
    output logic                a_valid,
    output logic                b_valid,
    output logic [NUM_REGS-1:0] busy
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_next;
    logic                write_en;
    logic [DATA_W-1:0]   byp_a, byp_b;
    logic                ready_a, ready_b;
    op_state_t           a_state, b_state;

    assign write_en = write && !((ZERO_R0 != 0) && (writenum == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (write_en) begin
            regs[writenum] <= data_in;
        end
    end

    // Reserve is applied after the write clear so a same-register reserve+write stays busy.
    always_comb begin
        busy_next = busy;
        if (write) busy_next[writenum] = 1'b0;
        if (reserve) busy_next[reservenum] = 1'b1;
        if (ZERO_R0 != 0) busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

    always_comb begin
        byp_a = (write && (writenum == readnum_a)) ? data_in : regs[readnum_a];
        if ((ZERO_R0 != 0) && (readnum_a == '0)) byp_a = '0;
        byp_b = (write && (writenum == readnum_b)) ? data_in : regs[readnum_b];
        if ((ZERO_R0 != 0) && (readnum_b == '0)) byp_b = '0;
    end

    assign ready_a  = !busy[readnum_a] || (write && (writenum == readnum_a));
    assign ready_b  = !busy[readnum_b] || (write && (writenum == readnum_b));
    assign data_out = regs[readnum_a];

    operand_latch #(.DATA_W(DATA_W), .AW(AW)) u_latch_a (
        .clk       (clk),
        .reset     (reset),
        .load      (loada),
        .ready     (ready_a),
        .readnum   (readnum_a),
        .byp_value (byp_a),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .operand   (A),
        .state     (a_state)
    );

    operand_latch #(.DATA_W(DATA_W), .AW(AW)) u_latch_b (
        .clk       (clk),
        .reset     (reset),
        .load      (loadb),
        .ready     (ready_b),
        .readnum   (readnum_b),
        .byp_value (byp_b),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .operand   (B),
        .state     (b_state)
    );

    assign a_valid = (a_state == OP_IDLE);
    assign b_valid = (b_state == OP_IDLE);

endmodule

// File: tb/tb_operand_regfile.sv
// Directed bench for operand_regfile: one default instance and one with reg0 hardwired to zero,
// both driven by the same stimulus.
module tb_operand_regfile;

    logic        clk;
    logic        reset;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic        reserve;
    logic [2:0]  reservenum;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic        loada;
    logic        loadb;

    logic [15:0] data_out, A, B;
    logic        a_valid, b_valid;
    logic [7:0]  busy;

    logic [15:0] z_data_out, z_A, z_B;
    logic        z_a_valid, z_b_valid;
    logic [7:0]  z_busy;

    int tests_run = 0;
    int tests_failed = 0;

    operand_regfile dut (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
        .reserve(reserve), .reservenum(reservenum), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .loada(loada), .loadb(loadb), .data_out(data_out), .A(A), .B(B),
        .a_valid(a_valid), .b_valid(b_valid), .busy(busy)
    );

    operand_regfile #(.ZERO_R0(1)) dut_z (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
        .reserve(reserve), .reservenum(reservenum), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .loada(loada), .loadb(loadb), .data_out(z_data_out), .A(z_A), .B(z_B),
        .a_valid(z_a_valid), .b_valid(z_b_valid), .busy(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        write = 1'b0; writenum = '0; data_in = '0;
        reserve = 1'b0; reservenum = '0;
        readnum_a = '0; readnum_b = '0;
        loada = 1'b0; loadb = 1'b0;
        #12;
        check("reset_A", A, 16'h0000);
        check("reset_B", B, 16'h0000);
        check("reset_a_valid", {15'd0, a_valid}, 16'd1);
        check("reset_b_valid", {15'd0, b_valid}, 16'd1);
        check("reset_busy", {8'd0, busy}, 16'h0000);
        reset = 1'b0;

        // 1: reset while A is waiting on a reserved register
        tick();
        reserve = 1'b1; reservenum = 3'd3;
        tick();
        reserve = 1'b0;
        check("t1_busy3", {8'd0, busy}, 16'h0008);
        loada = 1'b1; readnum_a = 3'd3;
        tick();
        loada = 1'b0;
        check("t1_wait_a_valid", {15'd0, a_valid}, 16'd0);
        reset = 1'b1;
        #1;
        check("t1_rst_A", A, 16'h0000);
        check("t1_rst_a_valid", {15'd0, a_valid}, 16'd1);
        check("t1_rst_busy", {8'd0, busy}, 16'h0000);
        reset = 1'b0;

        // 2: write then load both ports from the same register
        tick();
        write = 1'b1; writenum = 3'd2; data_in = 16'h1234;
        tick();
        write = 1'b0;
        loada = 1'b1; loadb = 1'b1; readnum_a = 3'd2; readnum_b = 3'd2;
        #1;
        check("t2_data_out", data_out, 16'h1234);
        tick();
        loada = 1'b0; loadb = 1'b0;
        check("t2_A", A, 16'h1234);
        check("t2_B", B, 16'h1234);
        check("t2_valids", {14'd0, a_valid, b_valid}, 16'd3);

        // 3: same-cycle write bypass into A
        write = 1'b1; writenum = 3'd5; data_in = 16'hBEEF;
        loada = 1'b1; readnum_a = 3'd5;
        tick();
        write = 1'b0; loada = 1'b0;
        check("t3_bypass_A", A, 16'hBEEF);

        // 4: scoreboard wait released by the clearing write
        reserve = 1'b1; reservenum = 3'd4;
        tick();
        reserve = 1'b0;
        check("t4_busy4", {8'd0, busy}, 16'h0010);
        loada = 1'b1; readnum_a = 3'd4;
        tick();
        loada = 1'b0;
        check("t4_a_valid_wait", {15'd0, a_valid}, 16'd0);
        check("t4_A_hold", A, 16'hBEEF);
        tick(); tick(); tick();
        check("t4_a_valid_still", {15'd0, a_valid}, 16'd0);
        write = 1'b1; writenum = 3'd4; data_in = 16'h00AA;
        tick();
        write = 1'b0;
        check("t4_A", A, 16'h00AA);
        check("t4_a_valid", {15'd0, a_valid}, 16'd1);
        check("t4_busy_clear", {8'd0, busy}, 16'h0000);

        // 5: B waits on r1 while A loads r6 independently
        write = 1'b1; writenum = 3'd6; data_in = 16'h5A5A;
        reserve = 1'b1; reservenum = 3'd1;
        tick();
        write = 1'b0; reserve = 1'b0;
        loadb = 1'b1; readnum_b = 3'd1;
        tick();
        loadb = 1'b0;
        check("t5_b_valid_wait", {15'd0, b_valid}, 16'd0);
        loada = 1'b1; readnum_a = 3'd6;
        tick();
        loada = 1'b0;
        check("t5_A", A, 16'h5A5A);
        check("t5_a_valid", {15'd0, a_valid}, 16'd1);
        check("t5_b_valid_still", {15'd0, b_valid}, 16'd0);
        write = 1'b1; writenum = 3'd1; data_in = 16'h0C0C;
        tick();
        write = 1'b0;
        check("t5_B", B, 16'h0C0C);
        check("t5_b_valid", {15'd0, b_valid}, 16'd1);
        check("t5_A_kept", A, 16'h5A5A);

        // reserve and write of the same register in one cycle: data lands, register stays busy
        write = 1'b1; writenum = 3'd7; data_in = 16'h7777;
        reserve = 1'b1; reservenum = 3'd7;
        readnum_a = 3'd7;
        tick();
        write = 1'b0; reserve = 1'b0;
        check("rw_busy7", {8'd0, busy}, 16'h0080);
        check("rw_data_out", data_out, 16'h7777);
        write = 1'b1; writenum = 3'd7; data_in = 16'h7778;
        tick();
        write = 1'b0;
        check("rw_busy_clear", {8'd0, busy}, 16'h0000);

        // 6: reg0 hardwired to zero on dut_z, ordinary on dut
        write = 1'b1; writenum = 3'd0; data_in = 16'hFFFF;
        tick();
        write = 1'b0;
        readnum_a = 3'd0;
        #1;
        check("t6_z_data_out", z_data_out, 16'h0000);
        check("t6_data_out", data_out, 16'hFFFF);
        check("t6_z_A_before", z_A, 16'h5A5A);
        loada = 1'b1;
        tick();
        loada = 1'b0;
        check("t6_z_A", z_A, 16'h0000);
        check("t6_A", A, 16'hFFFF);
        reserve = 1'b1; reservenum = 3'd0;
        tick();
        reserve = 1'b0;
        check("t6_z_busy", {8'd0, z_busy}, 16'h0000);
        check("t6_busy", {8'd0, busy}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
